rbcp_master: RTL and testbench

//  Command-driven RBCP initiator: turns a local burst request into byte-wise RBCP

---
 rtl/rbcp_pkg.sv | 20 ++
 rtl/rbcp_master.sv | 198 +++++++++++++++++++
 tb/tb_rbcp_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rbcp_pkg.sv
// Shared widths and FSM state encoding for the RBCP initiator.
package rbcp_pkg;

    localparam int unsigned RBCP_ADDR_W = 32;
    localparam int unsigned RBCP_DATA_W = 8;
    localparam int unsigned LEN_W       = 8;

    typedef enum logic [3:0] {
        StIdle,
        StActOn,
        StWaitWd,
        StStrobe,
        StWaitAck,
        StRdHold,
        StNext,
        StFinish,
        StGap
    } state_e;

endpackage

// File: rtl/rbcp_master.sv
// Command-driven RBCP initiator: splits a local burst into byte-wise WE/RE strobes.
// Optional ACK timeout abort is built when RBCP_TIMEOUT_EN is defined.
module rbcp_master
    import rbcp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned GAP_CYC     = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic                   CMD_WRITE,
    input  logic [RBCP_ADDR_W-1:0] CMD_ADDR,
    input  logic [LEN_W-1:0]       CMD_LEN,
    input  logic                   WD_VALID,
    output logic                   WD_READY,
    input  logic [RBCP_DATA_W-1:0] WD_DATA,
    output logic                   RD_VALID,
    input  logic                   RD_READY,
    output logic [RBCP_DATA_W-1:0] RD_DATA,
    output logic                   RD_LAST,
    output logic                   DONE,
    output logic                   ERR,
    output logic                   BUSY,
    output logic                   RBCP_ACT,
    output logic [RBCP_ADDR_W-1:0] RBCP_ADDR,
    output logic                   RBCP_WE,
    output logic [RBCP_DATA_W-1:0] RBCP_WD,
    output logic                   RBCP_RE,
    input  logic [RBCP_DATA_W-1:0] RBCP_RD,
    input  logic                   RBCP_ACK
);

    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    state_e                   state_q;
    logic                     write_q;
    logic [RBCP_ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]         cnt_q;
    logic [GapW-1:0]          gap_q;
    logic                     act_q, we_q, re_q, wd_ready_q;
    logic [RBCP_DATA_W-1:0]   wd_q, rd_data_q;
    logic                     rd_valid_q, rd_last_q, done_q;

`ifdef RBCP_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_q;
    logic            err_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            act_q      <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            wd_ready_q <= 1'b0;
            wd_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef RBCP_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (CMD_VALID) begin
                        write_q <= CMD_WRITE;
                        addr_q  <= CMD_ADDR;
                        cnt_q   <= CMD_LEN;
                        act_q   <= 1'b1;
`ifdef RBCP_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= StActOn;
                    end
                end
                StActOn: begin
                    if (write_q) begin
                        wd_ready_q <= 1'b1;
                        state_q    <= StWaitWd;
                    end else begin
                        re_q    <= 1'b1;
                        state_q <= StStrobe;
                    end
                end
                StWaitWd: begin
                    if (WD_VALID) begin
                        wd_q       <= WD_DATA;
                        we_q       <= 1'b1;
                        wd_ready_q <= 1'b0;
                        state_q    <= StStrobe;
                    end
                end
                StStrobe: begin
`ifdef RBCP_TIMEOUT_EN
                    tmo_q   <= TmoW'(1);
`endif
                    state_q <= StWaitAck;
                end
                StWaitAck: begin
                    if (RBCP_ACK) begin
                        if (write_q) begin
                            // Pre-open the write port so a ready byte can strobe straight from NEXT.
                            wd_ready_q <= (cnt_q != '0);
                            state_q    <= StNext;
                        end else begin
                            rd_data_q  <= RBCP_RD;
                            rd_valid_q <= 1'b1;
                            rd_last_q  <= (cnt_q == '0);
                            state_q    <= StRdHold;
                        end
                    end
`ifdef RBCP_TIMEOUT_EN
                    else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                        act_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
`endif
                end
                StRdHold: begin
                    if (RD_READY) begin
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                        state_q    <= StNext;
                    end
                end
                StNext: begin
                    if (cnt_q == '0) begin
                        act_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        addr_q <= addr_q + 32'd1;
                        cnt_q  <= cnt_q - 8'd1;
                        if (!write_q) begin
                            re_q    <= 1'b1;
                            state_q <= StStrobe;
                        end else if (WD_VALID) begin
                            wd_q       <= WD_DATA;
                            we_q       <= 1'b1;
                            wd_ready_q <= 1'b0;
                            state_q    <= StStrobe;
                        end else begin
                            state_q <= StWaitWd;
                        end
                    end
                end
                StFinish: begin
                    gap_q   <= '0;
                    state_q <= StGap;
                end
                StGap: begin
                    if (gap_q == GapW'(GAP_CYC - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign CMD_READY = (state_q == StIdle);
    assign BUSY      = (state_q != StIdle);
    assign WD_READY  = wd_ready_q;
    assign RD_VALID  = rd_valid_q;
    assign RD_DATA   = rd_data_q;
    assign RD_LAST   = rd_last_q;
    assign DONE      = done_q;
    assign RBCP_ACT  = act_q;
    assign RBCP_ADDR = addr_q;
    assign RBCP_WE   = we_q;
    assign RBCP_WD   = wd_q;
    assign RBCP_RE   = re_q;
`ifdef RBCP_TIMEOUT_EN
    assign ERR       = done_q & err_q;
`else
    assign ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_rbcp_master.sv
// Directed bench for rbcp_master: table of bursts plus reset, stray-ACK and timeout sequences.
module tb_rbcp_master;

    localparam int unsigned GAP = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [7:0]  CMD_LEN;
    logic        WD_VALID, WD_READY;
    logic [7:0]  WD_DATA;
    logic        RD_VALID, RD_READY, RD_LAST;
    logic [7:0]  RD_DATA;
    logic        DONE, ERR, BUSY;
    logic        RBCP_ACT, RBCP_WE, RBCP_RE, RBCP_ACK;
    logic [31:0] RBCP_ADDR;
    logic [7:0]  RBCP_WD, RBCP_RD;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    rbcp_master #(.TIMEOUT_CYC(16), .GAP_CYC(GAP)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
        .DONE(DONE), .ERR(ERR), .BUSY(BUSY),
        .RBCP_ACT(RBCP_ACT), .RBCP_ADDR(RBCP_ADDR), .RBCP_WE(RBCP_WE), .RBCP_WD(RBCP_WD),
        .RBCP_RE(RBCP_RE), .RBCP_RD(RBCP_RD), .RBCP_ACK(RBCP_ACK)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic         write;
        logic [31:0]  addr;
        logic [7:0]   len;
        logic [31:0]  data;      // byte i at [8*i +: 8]
        int           ack_dly;   // cycles from strobe to ACK
        int           rd_hold;   // cycles RD_READY stays low per read byte
        logic [127:0] exp_addr;  // expected strobe address i at [32*i +: 32]
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!CMD_READY && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", CMD_READY, 1);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        wait_ready();
        CMD_WRITE = wr;
        CMD_ADDR  = addr;
        CMD_LEN   = len;
        CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  strobes, rds, wds, ack_cnt, ack_idx, hold_cnt, last_strobe, n;
        bit  rd_seen, done_seen, act_seen, bad_act, bad_re, bad_wdr;
        strobes = 0; rds = 0; wds = 0; ack_cnt = 0; ack_idx = 0; hold_cnt = 0;
        last_strobe = 0; rd_seen = 0; done_seen = 0; act_seen = 0;
        bad_act = 0; bad_re = 0; bad_wdr = 0;
        n = int'(v.len) + 1;
        issue(v.write, v.addr, v.len);
        for (int c = 0; c < 300 && !done_seen; c++) begin
            RBCP_ACK = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    RBCP_ACK = 1'b1;
                    RBCP_RD  = v.data[8*ack_idx +: 8];
                end
            end
            if (RBCP_WE || RBCP_RE) begin
                check("strobe_we", RBCP_WE, v.write);
                check("strobe_re", RBCP_RE, !v.write);
                if (strobes < 4) begin
                    check("strobe_addr", RBCP_ADDR, v.exp_addr[32*strobes +: 32]);
                    if (v.write) check("strobe_wd", RBCP_WD, v.data[8*strobes +: 8]);
                end
                if (v.write && strobes > 0)
                    check("strobe_spacing", cyc - last_strobe, v.ack_dly + 2);
                last_strobe = cyc;
                ack_idx = (strobes < 4) ? strobes : 0;
                strobes++;
                ack_cnt = v.ack_dly;
            end
            if (RBCP_ACT) act_seen = 1;
            else if (act_seen && !DONE) bad_act = 1;
            if (RBCP_RE && RD_VALID) bad_re = 1;
            if (!v.write && WD_READY) bad_wdr = 1;
            RD_READY = 1'b0;
            if (RD_VALID) begin
                if (!rd_seen && rds < 4) begin
                    check("rd_data", RD_DATA, v.data[8*rds +: 8]);
                    check("rd_last", RD_LAST, (rds == int'(v.len)));
                end
                rd_seen = 1;
                if (hold_cnt >= v.rd_hold) begin
                    RD_READY = 1'b1;
                    rds++;
                    rd_seen = 0;
                    hold_cnt = 0;
                end else begin
                    hold_cnt++;
                end
            end
            // Source keeps offering bytes, even during reads where they must be ignored.
            WD_VALID = 1'b1;
            WD_DATA  = (wds < 4) ? v.data[8*wds +: 8] : 8'h00;
            if (WD_READY) wds++;
            if (DONE) begin
                done_seen = 1;
                check("done_err", ERR, 0);
                check("done_act", RBCP_ACT, 0);
            end else begin
                tick();
            end
        end
        RBCP_ACK = 1'b0;
        RD_READY = 1'b0;
        WD_VALID = 1'b0;
        check("done_seen", done_seen, 1);
        check("strobe_count", strobes, n);
        if (v.write) check("wd_taken", wds, n);
        else check("rd_count", rds, n);
        check("act_continuous", bad_act, 0);
        check("re_while_rd_valid", bad_re, 0);
        check("wd_ready_in_read", bad_wdr, 0);
        tick();
        check("done_pulse", DONE, 0);
        check("gap_busy", BUSY, 1);
        repeat (GAP - 1) tick();
        check("gap_not_ready", CMD_READY, 0);
        tick();
        check("ready_after_gap", CMD_READY, 1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 8'd3, {8'h44, 8'h33, 8'h22, 8'h11}, 2, 0,
                    {32'h13, 32'h12, 32'h11, 32'h10}};
        vecs[1] = '{1'b0, 32'h0002_0000, 8'd1, {16'h0, 8'h5A, 8'hA5}, 2, 5,
                    {64'h0, 32'h0002_0001, 32'h0002_0000}};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 8'd1, {16'h0, 8'h02, 8'h01}, 1, 0,
                    {64'h0, 32'h0000_0000, 32'hFFFF_FFFF}};
        vecs[3] = '{1'b1, 32'hFFFF_FFFE, 8'd2, {8'h0, 8'h09, 8'h08, 8'h07}, 1, 0,
                    {32'h0, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE}};
        vecs[4] = '{1'b0, 32'h0000_0100, 8'd0, {24'h0, 8'hC3}, 3, 1,
                    {96'h0, 32'h0000_0100}};

        RST = 1'b1; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_LEN = 0;
        WD_VALID = 0; WD_DATA = 0; RD_READY = 0; RBCP_ACK = 0; RBCP_RD = 0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check("rst_cmd_ready", CMD_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_act", RBCP_ACT, 0);
        check("rst_strobes", {RBCP_WE, RBCP_RE}, 0);
        check("rst_rd_valid", RD_VALID, 0);
        check("rst_done_err", {DONE, ERR}, 0);
        check("rst_wd_ready", WD_READY, 0);

        // Stray ACK while idle must not produce read data or start anything.
        RBCP_ACK = 1'b1; RBCP_RD = 8'hEE;
        tick();
        RBCP_ACK = 1'b0;
        tick();
        check("stray_ack_rd_valid", RD_VALID, 0);
        check("stray_ack_busy", BUSY, 0);
        check("stray_ack_ready", CMD_READY, 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset on the 3rd byte strobe of an 8-byte write.
        begin
            int we_n, ack_cnt;
            we_n = 0; ack_cnt = 0;
            issue(1'b1, 32'h0000_0200, 8'd7);
            for (int c = 0; c < 100 && we_n < 3; c++) begin
                RBCP_ACK = 1'b0;
                if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) RBCP_ACK = 1'b1;
                end
                WD_VALID = 1'b1;
                WD_DATA  = 8'(c);
                if (RBCP_WE) begin
                    we_n++;
                    ack_cnt = 1;
                end
                if (we_n < 3) tick();
            end
            check("rst_mid_we3_seen", we_n, 3);
            RBCP_ACK = 1'b0;
            WD_VALID = 1'b0;
            RST = 1'b1;
            tick();
            check("rst_mid_act", RBCP_ACT, 0);
            check("rst_mid_we", RBCP_WE, 0);
            check("rst_mid_done", DONE, 0);
            check("rst_mid_ready", CMD_READY, 1);
            RST = 1'b0;
            tick();
            check("rst_mid_after_busy", BUSY, 0);
            check("rst_mid_after_done", DONE, 0);
        end

`ifdef RBCP_TIMEOUT_EN
        // No ACK: abort 16 cycles after the RE strobe, then a late ACK is ignored.
        begin
            int re_cyc, k;
            bit got_done;
            got_done = 0;
            issue(1'b0, 32'h0000_0040, 8'd2);
            for (int c = 0; c < 20 && !RBCP_RE; c++) tick();
            check("tmo_re_seen", RBCP_RE, 1);
            re_cyc = cyc;
            for (k = 0; k < 40 && !DONE; k++) tick();
            check("tmo_done", DONE, 1);
            check("tmo_latency", cyc - re_cyc, 16);
            check("tmo_err", ERR, 1);
            check("tmo_act", RBCP_ACT, 0);
            check("tmo_rd_valid", RD_VALID, 0);
            RBCP_ACK = 1'b1; RBCP_RD = 8'h77;
            tick();
            RBCP_ACK = 1'b0;
            repeat (GAP + 2) tick();
            check("tmo_late_ack_rd_valid", RD_VALID, 0);
            check("tmo_idle", BUSY, 0);
            check("tmo_ready", CMD_READY, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
